// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register/ALU-op types, forwarding select and ID/EX state.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned RegW  = 5;

  typedef logic [WordW-1:0] word_t;
  typedef logic [RegW-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

  // ID/EX pipeline register contents
  typedef struct packed {
    logic     valid;
    aluop_t   alu_op;
    regbits_t rs;
    regbits_t rt;
    word_t    rdata1;
    word_t    rdata2;
    word_t    imm;
    logic     alusrc;
    regbits_t wsel;
    logic     regwen;
    logic     memread;
  } idex_t;

  // Youngest producer wins; $0 is hardwired zero and never forwarded.
  function automatic fwd_sel_t fwd_pick(regbits_t src, regbits_t mem_wsel, logic mem_regwen,
                                        regbits_t wb_wsel, logic wb_regwen);
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (mem_regwen && (mem_wsel != '0) && (mem_wsel == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwen && (wb_wsel != '0) && (wb_wsel == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/idex_operand_stage_if.sv
// Decode/forwarding-source inputs and ALU/EX-MEM outputs of the ID/EX operand stage.
interface idex_operand_stage_if;
  import cpu_types_pkg::*;

  logic     en;
  logic     flush;
  logic     id_valid;
  aluop_t   id_aluOp;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_use_rt;
  word_t    id_rdata1;
  word_t    id_rdata2;
  word_t    id_imm;
  logic     id_alusrc;
  regbits_t id_wsel;
  logic     id_regwen;
  logic     id_memread;
  regbits_t mem_wsel;
  logic     mem_regwen;
  word_t    mem_wdat;
  regbits_t wb_wsel;
  logic     wb_regwen;
  word_t    wb_wdat;

  aluop_t   aluOp;
  word_t    portA;
  word_t    portB;
  word_t    ex_store_data;
  logic     ex_valid;
  regbits_t ex_wsel;
  logic     ex_regwen;
  logic     ex_memread;
  logic     stall_id;

  modport slave (
    input  en, flush, id_valid, id_aluOp, id_rs, id_rt, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_alusrc, id_wsel, id_regwen, id_memread,
           mem_wsel, mem_regwen, mem_wdat, wb_wsel, wb_regwen, wb_wdat,
    output aluOp, portA, portB, ex_store_data, ex_valid, ex_wsel, ex_regwen, ex_memread,
           stall_id
  );

  modport master (
    output en, flush, id_valid, id_aluOp, id_rs, id_rt, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_alusrc, id_wsel, id_regwen, id_memread,
           mem_wsel, mem_regwen, mem_wdat, wb_wsel, wb_regwen, wb_wdat,
    input  aluOp, portA, portB, ex_store_data, ex_valid, ex_wsel, ex_regwen, ex_memread,
           stall_id
  );

endinterface

// File: rtl/idex_operand_stage_forward_unit.sv
// Combinational forwarding-source select for two source operands; shared with branch compare.
module forward_unit
  import cpu_types_pkg::*;
(
  input  regbits_t rs_i,
  input  regbits_t rt_i,
  input  regbits_t mem_wsel_i,
  input  logic     mem_regwen_i,
  input  regbits_t wb_wsel_i,
  input  logic     wb_regwen_i,
  output fwd_sel_t fwd_a_o,
  output fwd_sel_t fwd_b_o
);

  // A and B are resolved independently
  always_comb begin
    fwd_a_o = fwd_pick(rs_i, mem_wsel_i, mem_regwen_i, wb_wsel_i, wb_regwen_i);
    fwd_b_o = fwd_pick(rt_i, mem_wsel_i, mem_regwen_i, wb_wsel_i, wb_regwen_i);
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall generation.
module idex_operand_stage
  import cpu_types_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input logic                  CLK,
  input logic                  nRST,
  idex_operand_stage_if.slave  bus
);

  idex_t    idex_q, idex_d;
  logic     hazard;
  fwd_sel_t sel_a, sel_b;
  word_t    fwd_a, fwd_b;

  // Load in EX whose destination is read by the instruction in decode
  always_comb begin
    hazard = idex_q.valid & idex_q.memread & (idex_q.wsel != '0) & bus.id_valid &
             ((idex_q.wsel == bus.id_rs) | (bus.id_use_rt & (idex_q.wsel == bus.id_rt)));
  end

  // Next-state: hold when frozen, bubble on flush/hazard, otherwise latch decode
  always_comb begin
    idex_d = idex_q;
    if (bus.en) begin
      if (bus.flush || hazard) begin
        // Data fields are left as-is; only the side-effect bits are cleared.
        idex_d.valid   = 1'b0;
        idex_d.regwen  = 1'b0;
        idex_d.memread = 1'b0;
      end else begin
        idex_d.valid   = bus.id_valid;
        idex_d.alu_op  = bus.id_aluOp;
        idex_d.rs      = bus.id_rs;
        idex_d.rt      = bus.id_rt;
        idex_d.rdata1  = bus.id_rdata1;
        idex_d.rdata2  = bus.id_rdata2;
        idex_d.imm     = bus.id_imm;
        idex_d.alusrc  = bus.id_alusrc;
        idex_d.wsel    = bus.id_wsel;
        idex_d.regwen  = bus.id_regwen;
        idex_d.memread = bus.id_memread;
      end
    end
  end

  // Pipeline register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  forward_unit u_forward_unit (
    .rs_i         (idex_q.rs),
    .rt_i         (idex_q.rt),
    .mem_wsel_i   (bus.mem_wsel),
    .mem_regwen_i (bus.mem_regwen),
    .wb_wsel_i    (bus.wb_wsel),
    .wb_regwen_i  (bus.wb_regwen),
    .fwd_a_o      (sel_a),
    .fwd_b_o      (sel_b)
  );

  // Operand muxes; FWD_EN=0 pins both to the latched register-file data
  always_comb begin
    fwd_a = idex_q.rdata1;
    fwd_b = idex_q.rdata2;
    if (FWD_EN) begin
      case (sel_a)
        FWD_MEM: fwd_a = bus.mem_wdat;
        FWD_WB:  fwd_a = bus.wb_wdat;
        default: fwd_a = idex_q.rdata1;
      endcase
      case (sel_b)
        FWD_MEM: fwd_b = bus.mem_wdat;
        FWD_WB:  fwd_b = bus.wb_wdat;
        default: fwd_b = idex_q.rdata2;
      endcase
    end
  end

  assign bus.aluOp         = idex_q.alu_op;
  assign bus.portA         = fwd_a;
  assign bus.portB         = idex_q.alusrc ? idex_q.imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_wsel       = idex_q.wsel;
  assign bus.ex_regwen     = idex_q.valid & idex_q.regwen;
  assign bus.ex_memread    = idex_q.valid & idex_q.memread;
  assign bus.stall_id      = hazard;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed and random checks of idex_operand_stage against a behavioural EX-slot model.
module tb_idex_operand_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  idex_operand_stage_if bus ();

  idex_operand_stage #(.FWD_EN(1'b1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Model of what instruction currently occupies EX
  logic     m_valid, m_alusrc, m_regwen, m_memread;
  logic [3:0] m_aluop;
  regbits_t m_rs, m_rt, m_wsel;
  word_t    m_rd1, m_rd2, m_imm;

  function automatic word_t ref_operand(regbits_t r, word_t latched);
    if (bus.mem_regwen && r != 0 && bus.mem_wsel == r) return bus.mem_wdat;
    if (bus.wb_regwen && r != 0 && bus.wb_wsel == r) return bus.wb_wdat;
    return latched;
  endfunction

  function automatic logic ref_stall();
    if (!(m_valid && m_memread && bus.id_valid) || m_wsel == 0) return 1'b0;
    return (m_wsel == bus.id_rs) || (bus.id_use_rt && m_wsel == bus.id_rt);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    word_t b;
    b = ref_operand(m_rt, m_rd2);
    chk({tag, "/ex_valid"}, 32'(bus.ex_valid), 32'(m_valid));
    chk({tag, "/ex_regwen"}, 32'(bus.ex_regwen), 32'(m_valid & m_regwen));
    chk({tag, "/ex_memread"}, 32'(bus.ex_memread), 32'(m_valid & m_memread));
    chk({tag, "/ex_wsel"}, 32'(bus.ex_wsel), 32'(m_wsel));
    chk({tag, "/aluOp"}, 32'(bus.aluOp), 32'(m_aluop));
    chk({tag, "/portA"}, bus.portA, ref_operand(m_rs, m_rd1));
    chk({tag, "/portB"}, bus.portB, m_alusrc ? m_imm : b);
    chk({tag, "/store"}, bus.ex_store_data, b);
    chk({tag, "/stall"}, 32'(bus.stall_id), 32'(ref_stall()));
  endtask

  task automatic model_reset();
    {m_valid, m_alusrc, m_regwen, m_memread} = '0;
    m_aluop = '0;
    {m_rs, m_rt, m_wsel} = '0;
    {m_rd1, m_rd2, m_imm} = '0;
  endtask

  // One rising edge; the decision is taken on pre-edge state, applied after the edge
  task automatic tick();
    logic bubble, latch;
    bubble = bus.en && (bus.flush || ref_stall());
    latch  = bus.en && !bubble;
    @(posedge CLK);
    #1;
    if (bubble) begin
      m_valid = 0; m_regwen = 0; m_memread = 0;
    end else if (latch) begin
      m_valid = bus.id_valid;   m_aluop = bus.id_aluOp;  m_rs = bus.id_rs;
      m_rt = bus.id_rt;         m_rd1 = bus.id_rdata1;   m_rd2 = bus.id_rdata2;
      m_imm = bus.id_imm;       m_alusrc = bus.id_alusrc; m_wsel = bus.id_wsel;
      m_regwen = bus.id_regwen; m_memread = bus.id_memread;
    end
  endtask

  task automatic set_id(logic v, aluop_t op, regbits_t rs, regbits_t rt, logic use_rt,
                        word_t rd1, word_t rd2, word_t imm, logic alusrc, regbits_t wsel,
                        logic regwen, logic memread);
    bus.id_valid = v;   bus.id_aluOp = op;    bus.id_rs = rs;       bus.id_rt = rt;
    bus.id_use_rt = use_rt; bus.id_rdata1 = rd1; bus.id_rdata2 = rd2; bus.id_imm = imm;
    bus.id_alusrc = alusrc; bus.id_wsel = wsel; bus.id_regwen = regwen;
    bus.id_memread = memread;
  endtask

  task automatic no_fwd();
    bus.mem_wsel = '0; bus.mem_regwen = 1'b0; bus.mem_wdat = '0;
    bus.wb_wsel = '0;  bus.wb_regwen = 1'b0;  bus.wb_wdat = '0;
  endtask

  initial begin
    model_reset();
    bus.en = 1'b1;
    bus.flush = 1'b0;
    set_id(0, ALU_SLL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();

    // Reset state
    #12;
    check_all("reset");
    nRST = 1'b1;

    // Plain latch, no forwarding
    set_id(1, ALU_ADD, 1, 2, 1, 32'h11, 32'h22, 32'h0, 0, 5, 1, 0);
    tick();
    chk("basic/portA", bus.portA, 32'h11);
    chk("basic/portB", bus.portB, 32'h22);
    chk("basic/ex_valid", 32'(bus.ex_valid), 32'h1);
    check_all("basic");

    // MEM beats WB, then WB alone
    set_id(1, ALU_SUB, 3, 0, 1, 32'h5, 32'h0, 32'h0, 0, 6, 1, 0);
    tick();
    bus.mem_regwen = 1; bus.mem_wsel = 3; bus.mem_wdat = 32'hAAAA;
    bus.wb_regwen = 1;  bus.wb_wsel = 3;  bus.wb_wdat = 32'hBBBB;
    #1;
    chk("mem_prio/portA", bus.portA, 32'hAAAA);
    bus.mem_regwen = 0;
    #1;
    chk("wb_only/portA", bus.portA, 32'hBBBB);

    // $0 is never forwarded
    bus.mem_regwen = 1; bus.mem_wsel = 0; bus.mem_wdat = 32'hFFFF; bus.wb_regwen = 0;
    #1;
    chk("r0/portB", bus.portB, 32'h0);
    chk("r0/store", bus.ex_store_data, 32'h0);
    check_all("r0");

    // Immediate on portB while store data still carries the forwarded rt
    set_id(1, ALU_ADD, 1, 3, 1, 32'h1, 32'h77, 32'hFFFF_FFFC, 1, 8, 0, 0);
    tick();
    bus.mem_regwen = 1; bus.mem_wsel = 3; bus.mem_wdat = 32'h1234;
    #1;
    chk("imm/portB", bus.portB, 32'hFFFF_FFFC);
    chk("imm/store", bus.ex_store_data, 32'h1234);
    no_fwd();

    // Load-use: stall, bubble, then dependent forwards from MEM
    set_id(1, ALU_ADD, 1, 2, 0, 32'h0, 32'h0, 32'h10, 1, 4, 1, 1);
    tick();
    set_id(1, ALU_OR, 4, 2, 1, 32'h40, 32'h2, 32'h0, 0, 7, 1, 0);
    #1;
    chk("lu/stall", 32'(bus.stall_id), 32'h1);
    tick();
    chk("lu_bubble/ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("lu_bubble/stall", 32'(bus.stall_id), 32'h0);
    tick();
    bus.mem_regwen = 1; bus.mem_wsel = 4; bus.mem_wdat = 32'hCAFE;
    #1;
    chk("lu_dep/portA", bus.portA, 32'hCAFE);
    check_all("lu_dep");
    no_fwd();

    // Hazard and flush together still yield one bubble
    set_id(1, ALU_ADD, 1, 2, 0, 32'h0, 32'h0, 32'h10, 1, 9, 1, 1);
    tick();
    set_id(1, ALU_AND, 2, 9, 1, 32'h3, 32'h4, 32'h0, 0, 10, 1, 0);
    bus.flush = 1;
    #1;
    chk("flush_hz/stall", 32'(bus.stall_id), 32'h1);
    tick();
    bus.flush = 0;
    chk("flush_hz/ex_valid", 32'(bus.ex_valid), 32'h0);
    check_all("flush_hz");

    // Freeze for three cycles with changing decode inputs
    set_id(1, ALU_XOR, 11, 12, 1, 32'h1111, 32'h2222, 32'h0, 0, 13, 1, 0);
    tick();
    bus.en = 0;
    for (int i = 0; i < 3; i++) begin
      set_id(1, ALU_NOR, regbits_t'($urandom_range(1, 7)), regbits_t'($urandom_range(1, 7)),
             1, $urandom, $urandom, $urandom, 1, 14, 0, 1);
      tick();
      chk("freeze/portA", bus.portA, 32'h1111);
      chk("freeze/portB", bus.portB, 32'h2222);
      chk("freeze/aluOp", 32'(bus.aluOp), 32'(ALU_XOR));
      check_all("freeze");
    end
    bus.en = 1;

    // Asynchronous reset in the middle of a stall
    set_id(1, ALU_ADD, 1, 2, 0, 32'h0, 32'h0, 32'h8, 1, 5, 1, 1);
    tick();
    set_id(1, ALU_ADD, 5, 0, 0, 32'h0, 32'h0, 32'h0, 0, 6, 1, 0);
    #1;
    chk("arst_pre/stall", 32'(bus.stall_id), 32'h1);
    nRST = 0;
    #1;
    model_reset();
    chk("arst/ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("arst/ex_memread", 32'(bus.ex_memread), 32'h0);
    chk("arst/stall", 32'(bus.stall_id), 32'h0);
    check_all("arst");
    #1;
    nRST = 1;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_id(logic'($urandom_range(0, 1)), aluop_t'(4'($urandom_range(0, 9))),
             regbits_t'($urandom_range(0, 7)), regbits_t'($urandom_range(0, 7)),
             logic'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             logic'($urandom_range(0, 1)), regbits_t'($urandom_range(0, 7)),
             logic'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      tick();
      bus.mem_wsel = regbits_t'($urandom_range(0, 7));
      bus.mem_regwen = logic'($urandom_range(0, 1));
      bus.mem_wdat = $urandom;
      bus.wb_wsel = regbits_t'($urandom_range(0, 7));
      bus.wb_regwen = logic'($urandom_range(0, 1));
      bus.wb_wdat = $urandom;
      #1;
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
